// File: rtl/ee457_pcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ee457_pcpu_pkg
// Purpose  : Shared opcodes, pc_src/forwarding encodings and control bundle.
// Revision : 1.0
// ============================================================================
package ee457_pcpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_JR     = 2'b11;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef struct packed {
    logic       regw;
    logic       mr;
    logic       mw;
    logic       mtor;
    logic       alusrc;
    logic [1:0] aluop;
    logic       branch;
    logic       is_beq;
    logic       link;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/ee457_pcpu_fwd.sv
`default_nettype none
// ============================================================================
// Module   : ee457_pcpu_fwd
// Purpose  : EX-stage operand forwarding select for rs (fwd_a) and rt (fwd_b).
// Revision : 1.0
// ============================================================================
module ee457_pcpu_fwd
  import ee457_pcpu_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              exmem_regw,
  input  logic [REG_AW-1:0] exmem_dst,
  input  logic              memwb_regw,
  input  logic [REG_AW-1:0] memwb_dst,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  // The younger EX/MEM result wins when both later stages write the same register.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (exmem_regw && (exmem_dst != '0) && (exmem_dst == src))
      return FWD_EXMEM;
    else if (memwb_regw && (memwb_dst != '0) && (memwb_dst == src))
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(ex_rs);
    fwd_b = fwd_sel(ex_rt);
  end

endmodule
`default_nettype wire

// File: rtl/ee457_pcpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ee457_pcpu_ctrl
// Purpose  : 5-stage pipeline control: decode, hazards, flush, forwarding.
//            Macro EE457_PCPU_JAL_EN adds JAL/JR decode and the wb_link port.
// Revision : 1.0
// ============================================================================
module ee457_pcpu_ctrl
  import ee457_pcpu_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        id_op,
  input  logic [5:0]        id_func,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              mem_zero,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic [1:0]        pc_src,
  output logic              ex_alusrc,
  output logic [1:0]        ex_aluop,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic              mem_mr,
  output logic              mem_mw,
  output logic              wb_regw,
  output logic              wb_mtor,
  output logic [REG_AW-1:0] wb_dst
`ifdef EE457_PCPU_JAL_EN
  ,
  output logic              wb_link
`endif
);

  localparam logic [REG_AW-1:0] LINK_DST = REG_AW'(LINK_REG);

  ctrl_t             id_ctrl;
  logic [REG_AW-1:0] id_dst;
  logic              id_jmp;
  logic              id_jr;
  logic              load_use;
  logic              br_taken;

  ctrl_t             idex_ctrl_q,  idex_ctrl_d;
  logic [REG_AW-1:0] idex_rs_q,    idex_rs_d;
  logic [REG_AW-1:0] idex_rt_q,    idex_rt_d;
  logic [REG_AW-1:0] idex_dst_q,   idex_dst_d;
  ctrl_t             exmem_ctrl_q, exmem_ctrl_d;
  logic [REG_AW-1:0] exmem_dst_q,  exmem_dst_d;
  ctrl_t             memwb_ctrl_q, memwb_ctrl_d;
  logic [REG_AW-1:0] memwb_dst_q,  memwb_dst_d;

  always_comb begin
    id_ctrl = CTRL_BUBBLE;
    id_dst  = '0;
    id_jmp  = 1'b0;
    id_jr   = 1'b0;
    case (id_op)
      OP_RTYPE: begin
        if (id_func == FUNC_JR) begin
`ifdef EE457_PCPU_JAL_EN
          id_jr = 1'b1;
`endif
        end else begin
          id_ctrl.regw  = 1'b1;
          id_ctrl.aluop = ALUOP_FUNC;
          id_dst        = id_rd;
        end
      end
      OP_LW: begin
        id_ctrl.regw   = 1'b1;
        id_ctrl.mr     = 1'b1;
        id_ctrl.mtor   = 1'b1;
        id_ctrl.alusrc = 1'b1;
        id_dst         = id_rt;
      end
      OP_SW: begin
        id_ctrl.mw     = 1'b1;
        id_ctrl.alusrc = 1'b1;
      end
      OP_ADDI: begin
        id_ctrl.regw   = 1'b1;
        id_ctrl.alusrc = 1'b1;
        id_ctrl.aluop  = ALUOP_ADD;
        id_dst         = id_rt;
      end
      OP_BEQ: begin
        id_ctrl.branch = 1'b1;
        id_ctrl.is_beq = 1'b1;
        id_ctrl.aluop  = ALUOP_SUB;
      end
      OP_BNE: begin
        id_ctrl.branch = 1'b1;
        id_ctrl.aluop  = ALUOP_SUB;
      end
      OP_J: id_jmp = 1'b1;
`ifdef EE457_PCPU_JAL_EN
      OP_JAL: begin
        id_jmp       = 1'b1;
        id_ctrl.regw = 1'b1;
        id_ctrl.link = 1'b1;
        id_dst       = LINK_DST;
      end
`endif
      default: ;
    endcase
    // r0 is hard-wired zero: a write to it is dropped at the source.
    if (id_dst == '0)
      id_ctrl.regw = 1'b0;
  end

  always_comb begin
    load_use = idex_ctrl_q.mr && (idex_dst_q != '0) &&
               ((idex_dst_q == id_rs) || (idex_dst_q == id_rt));
    br_taken = exmem_ctrl_q.branch && (mem_zero ~^ exmem_ctrl_q.is_beq);
  end

  // A stalled jump is retried next cycle rather than flushed out of IF/ID.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    pc_src     = PC_SEQ;
    if (!rst) begin
      if (br_taken) begin
        pc_src     = PC_BRANCH;
        ifid_flush = 1'b1;
      end else if (load_use) begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
      end else if (id_jmp) begin
        pc_src     = PC_JUMP;
        ifid_flush = 1'b1;
      end else if (id_jr) begin
        pc_src     = PC_JR;
        ifid_flush = 1'b1;
      end
    end
  end

  always_comb begin
    idex_ctrl_d = id_ctrl;
    idex_rs_d   = id_rs;
    idex_rt_d   = id_rt;
    idex_dst_d  = id_dst;
    if (br_taken || load_use) begin
      idex_ctrl_d = CTRL_BUBBLE;
      idex_rs_d   = '0;
      idex_rt_d   = '0;
      idex_dst_d  = '0;
    end
    exmem_ctrl_d = br_taken ? CTRL_BUBBLE : idex_ctrl_q;
    exmem_dst_d  = br_taken ? '0 : idex_dst_q;
    memwb_ctrl_d = exmem_ctrl_q;
    memwb_dst_d  = exmem_dst_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_ctrl_q  <= CTRL_BUBBLE;
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      idex_dst_q   <= '0;
      exmem_ctrl_q <= CTRL_BUBBLE;
      exmem_dst_q  <= '0;
      memwb_ctrl_q <= CTRL_BUBBLE;
      memwb_dst_q  <= '0;
    end else begin
      idex_ctrl_q  <= idex_ctrl_d;
      idex_rs_q    <= idex_rs_d;
      idex_rt_q    <= idex_rt_d;
      idex_dst_q   <= idex_dst_d;
      exmem_ctrl_q <= exmem_ctrl_d;
      exmem_dst_q  <= exmem_dst_d;
      memwb_ctrl_q <= memwb_ctrl_d;
      memwb_dst_q  <= memwb_dst_d;
    end
  end

  ee457_pcpu_fwd #(
    .REG_AW (REG_AW)
  ) u_fwd (
    .ex_rs      (idex_rs_q),
    .ex_rt      (idex_rt_q),
    .exmem_regw (exmem_ctrl_q.regw),
    .exmem_dst  (exmem_dst_q),
    .memwb_regw (memwb_ctrl_q.regw),
    .memwb_dst  (memwb_dst_q),
    .fwd_a      (ex_fwd_a),
    .fwd_b      (ex_fwd_b)
  );

  assign ex_alusrc = idex_ctrl_q.alusrc;
  assign ex_aluop  = idex_ctrl_q.aluop;
  assign mem_mr    = exmem_ctrl_q.mr;
  assign mem_mw    = exmem_ctrl_q.mw;
  assign wb_regw   = memwb_ctrl_q.regw;
  assign wb_mtor   = memwb_ctrl_q.mtor;
  assign wb_dst    = memwb_dst_q;

  // MEM/WB carries the full bundle; only the write-back fields leave the block.
  logic unused_bits;
`ifdef EE457_PCPU_JAL_EN
  assign wb_link     = memwb_ctrl_q.link;
  assign unused_bits = ^memwb_ctrl_q;
`else
  assign unused_bits = ^{memwb_ctrl_q, LINK_DST};
`endif

endmodule
`default_nettype wire

// File: tb/tb_ee457_pcpu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ee457_pcpu_ctrl
// Purpose  : Directed self-checking bench for ee457_pcpu_ctrl.
// Revision : 1.0
// ============================================================================
module tb_ee457_pcpu_ctrl;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_NOP  = 6'h3F;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_JR    = 6'h08;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] id_op, id_func;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       mem_zero;
  logic       pc_we, ifid_we, ifid_flush;
  logic [1:0] pc_src;
  logic       ex_alusrc;
  logic [1:0] ex_aluop;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  logic       mem_mr, mem_mw;
  logic       wb_regw, wb_mtor;
  logic [4:0] wb_dst;
`ifdef EE457_PCPU_JAL_EN
  logic       wb_link;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ee457_pcpu_ctrl #(
    .REG_AW   (5),
    .LINK_REG (31)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_op      (id_op),
    .id_func    (id_func),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .mem_zero   (mem_zero),
    .pc_we      (pc_we),
    .ifid_we    (ifid_we),
    .ifid_flush (ifid_flush),
    .pc_src     (pc_src),
    .ex_alusrc  (ex_alusrc),
    .ex_aluop   (ex_aluop),
    .ex_fwd_a   (ex_fwd_a),
    .ex_fwd_b   (ex_fwd_b),
    .mem_mr     (mem_mr),
    .mem_mw     (mem_mw),
    .wb_regw    (wb_regw),
    .wb_mtor    (wb_mtor),
    .wb_dst     (wb_dst)
`ifdef EE457_PCPU_JAL_EN
    ,
    .wb_link    (wb_link)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [5:0] op, input logic [5:0] func,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_op   = op;
    id_func = func;
    id_rs   = rs;
    id_rt   = rt;
    id_rd   = rd;
  endtask

  task automatic nop();
    set_id(OP_NOP, 6'h00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    mem_zero = 1'b0;
    set_id(OP_J, 6'h00, 5'd0, 5'd0, 5'd0);
    #3;
    check("rst_pc_we",    pc_we,      8'd1);
    check("rst_ifid_we",  ifid_we,    8'd1);
    check("rst_flush",    ifid_flush, 8'd0);
    check("rst_pc_src",   pc_src,     8'd0);
    check("rst_fwd_a",    ex_fwd_a,   8'd0);
    check("rst_fwd_b",    ex_fwd_b,   8'd0);
    check("rst_mem_mr",   mem_mr,     8'd0);
    check("rst_mem_mw",   mem_mw,     8'd0);
    check("rst_wb_regw",  wb_regw,    8'd0);
    check("rst_alusrc",   ex_alusrc,  8'd0);
    @(negedge clk);
    rst = 1'b0;
    nop();
    next_cycle();

    // Load-use: LW r2 ; ADD r3,r2,r4
    set_id(OP_LW, 6'h00, 5'd1, 5'd2, 5'd0);
    sample();
    check("lw_id_pc_we", pc_we, 8'd1);
    next_cycle();
    set_id(OP_R, F_ADD, 5'd2, 5'd4, 5'd3);
    sample();
    check("lu_pc_we",     pc_we,     8'd0);
    check("lu_ifid_we",   ifid_we,   8'd0);
    check("lu_ex_alusrc", ex_alusrc, 8'd1);
    next_cycle();
    sample();
    check("lu_one_cycle_pc_we",   pc_we,     8'd1);
    check("lu_one_cycle_ifid_we", ifid_we,   8'd1);
    check("lu_bubble_alusrc",     ex_alusrc, 8'd0);
    check("lu_bubble_aluop",      ex_aluop,  8'd0);
    check("lu_lw_mem_mr",         mem_mr,    8'd1);
    next_cycle();
    nop();
    sample();
    check("lu_fwd_a",   ex_fwd_a, 8'd1);
    check("lu_fwd_b",   ex_fwd_b, 8'd0);
    check("lu_aluop",   ex_aluop, 8'd2);
    check("lw_wb_regw", wb_regw,  8'd1);
    check("lw_wb_mtor", wb_mtor,  8'd1);
    check("lw_wb_dst",  wb_dst,   8'd2);
    next_cycle();

    // ADD r5,r1,r1 ; SUB r6,r5,r5 -> EX/MEM forward on both
    set_id(OP_R, F_ADD, 5'd1, 5'd1, 5'd5);
    next_cycle();
    set_id(OP_R, F_SUB, 5'd5, 5'd5, 5'd6);
    sample();
    check("alu_alu_no_stall", pc_we, 8'd1);
    next_cycle();
    nop();
    sample();
    check("exmem_fwd_a", ex_fwd_a, 8'd2);
    check("exmem_fwd_b", ex_fwd_b, 8'd2);
    next_cycle();

    // ADD r7 ; NOP ; SUB r8,r7,r7 -> MEM/WB forward on both
    set_id(OP_R, F_ADD, 5'd1, 5'd1, 5'd7);
    next_cycle();
    nop();
    next_cycle();
    set_id(OP_R, F_SUB, 5'd7, 5'd7, 5'd8);
    next_cycle();
    nop();
    sample();
    check("memwb_fwd_a", ex_fwd_a, 8'd1);
    check("memwb_fwd_b", ex_fwd_b, 8'd1);
    next_cycle();

    // Both stages write r9: younger (EX/MEM) must win
    set_id(OP_R, F_ADD, 5'd1, 5'd1, 5'd9);
    next_cycle();
    set_id(OP_R, F_ADD, 5'd2, 5'd2, 5'd9);
    next_cycle();
    set_id(OP_R, F_SUB, 5'd9, 5'd1, 5'd10);
    next_cycle();
    nop();
    sample();
    check("fwd_prio_a", ex_fwd_a, 8'd2);
    check("fwd_prio_b", ex_fwd_b, 8'd0);
    next_cycle();

    // ADDI r0,r1,7 then a reader of r0
    set_id(OP_ADDI, 6'h00, 5'd1, 5'd0, 5'd0);
    next_cycle();
    set_id(OP_R, F_ADD, 5'd0, 5'd0, 5'd11);
    sample();
    check("addi_ex_alusrc", ex_alusrc, 8'd1);
    check("addi_ex_aluop",  ex_aluop,  8'd0);
    next_cycle();
    nop();
    sample();
    check("r0_fwd_a", ex_fwd_a, 8'd0);
    check("r0_fwd_b", ex_fwd_b, 8'd0);
    next_cycle();
    sample();
    check("addi_r0_wb_regw", wb_regw, 8'd0);
    next_cycle();

    // LW r0 followed by a reader of r0 must not stall
    set_id(OP_LW, 6'h00, 5'd1, 5'd0, 5'd0);
    next_cycle();
    set_id(OP_R, F_ADD, 5'd0, 5'd3, 5'd12);
    sample();
    check("lw_r0_no_stall", pc_we, 8'd1);
    next_cycle();
    nop();
    next_cycle();
    next_cycle();
    next_cycle();

    // BEQ taken: SW and ADD r12 behind it are squashed
    mem_zero = 1'b1;
    set_id(OP_BEQ, 6'h00, 5'd1, 5'd2, 5'd0);
    next_cycle();
    set_id(OP_SW, 6'h00, 5'd1, 5'd2, 5'd0);
    next_cycle();
    set_id(OP_R, F_ADD, 5'd1, 5'd1, 5'd12);
    sample();
    check("beq_pc_src", pc_src,     8'd1);
    check("beq_flush",  ifid_flush, 8'd1);
    check("beq_pc_we",  pc_we,      8'd1);
    next_cycle();
    nop();
    sample();
    check("beq_kill_sw_mw",   mem_mw,   8'd0);
    check("beq_kill_add_ex",  ex_aluop, 8'd0);
    next_cycle();
    sample();
    check("beq_kill_add_mem_mw", mem_mw,  8'd0);
    check("beq_kill_sw_wb",      wb_regw, 8'd0);
    next_cycle();
    sample();
    check("beq_kill_add_wb", wb_regw, 8'd0);
    next_cycle();

    // BNE with zero set is not taken
    set_id(OP_BNE, 6'h00, 5'd1, 5'd2, 5'd0);
    next_cycle();
    nop();
    next_cycle();
    sample();
    check("bne_pc_src", pc_src,     8'd0);
    check("bne_flush",  ifid_flush, 8'd0);
    next_cycle();

    // Plain J
    set_id(OP_J, 6'h00, 5'd0, 5'd0, 5'd0);
    sample();
    check("j_pc_src", pc_src,     8'd2);
    check("j_flush",  ifid_flush, 8'd1);
    next_cycle();
    nop();
    next_cycle();

    // J in ID while BEQ taken in MEM: branch wins
    set_id(OP_BEQ, 6'h00, 5'd1, 5'd2, 5'd0);
    next_cycle();
    nop();
    next_cycle();
    set_id(OP_J, 6'h00, 5'd0, 5'd0, 5'd0);
    sample();
    check("br_over_j_pc_src", pc_src,     8'd1);
    check("br_over_j_flush",  ifid_flush, 8'd1);
    next_cycle();
    mem_zero = 1'b0;
    nop();
    next_cycle();
    next_cycle();
    next_cycle();

    // Asynchronous reset in the middle of a load-use stall
    set_id(OP_LW, 6'h00, 5'd1, 5'd2, 5'd0);
    next_cycle();
    set_id(OP_R, F_ADD, 5'd2, 5'd4, 5'd3);
    sample();
    check("pre_rst_stall", pc_we, 8'd0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_pc_we",   pc_we,     8'd1);
    check("async_rst_ifid_we", ifid_we,   8'd1);
    check("async_rst_alusrc",  ex_alusrc, 8'd0);
    #1 rst = 1'b0;
    #1;
    check("post_rst_pc_we", pc_we, 8'd1);
    next_cycle();
    nop();
    sample();
    check("post_rst_no_lw_mem", mem_mr, 8'd0);
    next_cycle();
    next_cycle();
    next_cycle();

    // JAL / JR
    set_id(OP_JAL, 6'h00, 5'd0, 5'd0, 5'd0);
    sample();
`ifdef EE457_PCPU_JAL_EN
    check("jal_pc_src", pc_src,     8'd2);
    check("jal_flush",  ifid_flush, 8'd1);
`else
    check("jal_nop_pc_src", pc_src,     8'd0);
    check("jal_nop_flush",  ifid_flush, 8'd0);
`endif
    next_cycle();
    nop();
    next_cycle();
    next_cycle();
    sample();
`ifdef EE457_PCPU_JAL_EN
    check("jal_wb_regw", wb_regw, 8'd1);
    check("jal_wb_dst",  wb_dst,  8'd31);
    check("jal_wb_link", wb_link, 8'd1);
`else
    check("jal_nop_wb_regw", wb_regw, 8'd0);
`endif
    next_cycle();
    set_id(OP_R, F_JR, 5'd31, 5'd0, 5'd0);
    sample();
`ifdef EE457_PCPU_JAL_EN
    check("jr_pc_src", pc_src,     8'd3);
    check("jr_flush",  ifid_flush, 8'd1);
`else
    check("jr_nop_pc_src", pc_src,     8'd0);
    check("jr_nop_flush",  ifid_flush, 8'd0);
`endif
    next_cycle();
    nop();
    next_cycle();
    next_cycle();
    sample();
    check("jr_wb_regw", wb_regw, 8'd0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
